// File: rtl/acc_job_arbiter_if.sv
// Stream bundle between the job arbiter, its requesters and the shared accelerator.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface acc_job_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      acc_in_valid;
  logic [DATA_W-1:0]         acc_in_data;
  logic                      acc_in_ready;
  logic                      acc_out_valid;
  logic [DATA_W-1:0]         acc_out_data;
  logic                      acc_out_ready;

  modport master (
    input  req_valid, req_data, rsp_ready, acc_in_ready, acc_out_valid, acc_out_data,
    output req_ready, rsp_valid, rsp_data, acc_in_valid, acc_in_data, acc_out_ready
  );

  modport slave (
    output req_valid, req_data, rsp_ready, acc_in_ready, acc_out_valid, acc_out_data,
    input  req_ready, rsp_valid, rsp_data, acc_in_valid, acc_in_data, acc_out_ready
  );
endinterface

// File: rtl/acc_job_arbiter.sv
// Job-granular round-robin arbiter sharing one accelerator among NUM_REQ requesters.
// A grant covers a whole job: in_ratio input beats, then out_ratio output beats.
// Optional drain watchdog enabled by defining ACC_ARB_TIMEOUT_EN.
module acc_job_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_W-1:0]           in_ratio,
  input  logic [CNT_W-1:0]           out_ratio,
  acc_job_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [ID_W-1:0]  grant_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [ID_W-1:0]  pick;
  logic             pick_found;
  logic [CNT_W-1:0] in_ratio_q;
  logic [CNT_W-1:0] out_ratio_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] in_cnt_next;
  logic [CNT_W-1:0] out_cnt_next;
  logic             in_hs;
  logic             out_hs;
  logic             feed_open;
  logic             drain_open;
  logic             feed_done;
  logic             drain_done;
  logic             wdog_abort;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("acc_job_arbiter: illegal parameter value");
  end

  // First valid requester at or above rr_ptr, with wrap-around
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_found && bus.req_valid[ID_W'(idx)]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Beat accounting; a counter equal to its ratio closes the beat window (covers ratio 0)
  assign feed_open    = (in_cnt_q != in_ratio_q);
  assign drain_open   = (out_cnt_q != out_ratio_q);
  assign in_hs        = bus.acc_in_valid && bus.acc_in_ready;
  assign out_hs       = bus.acc_out_valid && bus.acc_out_ready;
  assign in_cnt_next  = in_cnt_q + CNT_W'(in_hs);
  assign out_cnt_next = out_cnt_q + CNT_W'(out_hs);
  assign feed_done    = (in_cnt_next == in_ratio_q);
  assign drain_done   = (out_cnt_next == out_ratio_q);
  assign rr_ptr_next  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

`ifdef ACC_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  // Drain watchdog: zero outside S_DRAIN and after each output handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q != S_DRAIN || out_hs) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end
  end

  assign wdog_abort = (state_q == S_DRAIN) && !out_hs && !drain_done &&
                      (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_abort = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = S_FEED;
      S_FEED:  if (feed_done) state_d = S_DRAIN;
      S_DRAIN: if (drain_done || wdog_abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job context: grant, latched ratios, beat counters, round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      in_ratio_q  <= '0;
      out_ratio_q <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q     <= pick;
            in_ratio_q  <= in_ratio;
            out_ratio_q <= out_ratio;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
          end
        end
        S_FEED: in_cnt_q <= in_cnt_next;
        S_DRAIN: begin
          out_cnt_q <= out_cnt_next;
          if (drain_done || wdog_abort) rr_ptr_q <= rr_ptr_next;
        end
        default: ;
      endcase
    end
  end

  // Stream routing for the granted requester; everything else held off
  always_comb begin
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.acc_in_valid  = 1'b0;
    bus.acc_out_ready = 1'b0;
    bus.acc_in_data   = bus.req_data[32'(grant_q) * DATA_W +: DATA_W];
    bus.rsp_data      = bus.acc_out_data;
    busy              = (state_q != S_IDLE);
    case (state_q)
      S_FEED: begin
        bus.acc_in_valid       = bus.req_valid[grant_q] && feed_open;
        bus.req_ready[grant_q] = bus.acc_in_ready && feed_open;
      end
      S_DRAIN: begin
        bus.rsp_valid[grant_q] = bus.acc_out_valid && drain_open;
        bus.acc_out_ready      = bus.rsp_ready[grant_q] && drain_open;
      end
      default: ;
    endcase
  end

  assign grant_id    = grant_q;
  assign timeout_err = wdog_abort;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Directed bench for acc_job_arbiter: vector table for one full job, then hand-written
// sequences for round-robin order, ratio latching, zero ratios and the drain watchdog.
module tb_acc_job_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TMO     = 8;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] in_ratio;
  logic [CNT_W-1:0] out_ratio;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;

  acc_job_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  acc_job_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_ratio(in_ratio), .out_ratio(out_ratio),
    .bus(bus), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req_valid;
    logic       acc_in_ready;
    logic       acc_out_valid;
    logic [3:0] rsp_ready;
    logic [3:0] e_req_ready;
    logic       e_acc_in_valid;
    logic [3:0] e_rsp_valid;
    logic       e_acc_out_ready;
    logic       e_busy;
    logic [1:0] e_grant;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [3:0] rv, logic air, logic aov, logic [3:0] rr,
                              logic [3:0] erq, logic eaiv, logic [3:0] ersp,
                              logic eaor, logic eb, logic [1:0] eg);
    vec_t v;
    v.req_valid = rv;  v.acc_in_ready = air;  v.acc_out_valid = aov;  v.rsp_ready = rr;
    v.e_req_ready = erq;  v.e_acc_in_valid = eaiv;  v.e_rsp_valid = ersp;
    v.e_acc_out_ready = eaor;  v.e_busy = eb;  v.e_grant = eg;
    return v;
  endfunction

  function automatic logic [63:0] req_word(int i);
    return 64'hD00D_0000_0000_0000 + 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic air, input logic aov, input logic [3:0] rr);
    bus.req_valid     = rv;
    bus.acc_in_ready  = air;
    bus.acc_out_valid = aov;
    bus.rsp_ready     = rr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 4'b0000);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Runs one job from its S_IDLE arbitration cycle until busy falls; inputs held static.
  task automatic run_job(input string tag, input int g, input int n_in, input int n_out,
                         input int n_busy, input bit do_chg, input logic [CNT_W-1:0] new_in);
    int ci = 0;
    int co = 0;
    int cb = 0;
    int stray = 0;
    int guard = 0;
    logic [3:0] gmask;
    gmask = 4'b0001 << g;
    #1;
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    step();
    #1;
    chk({tag, " grant"}, 64'(grant_id), 64'(g));
    while (busy && guard < 200) begin
      if ((bus.rsp_valid & ~gmask) != 0 || (bus.req_ready & ~gmask) != 0) stray++;
      if (bus.acc_in_valid && bus.acc_in_ready) begin
        ci++;
        chk({tag, " in_data"}, bus.acc_in_data, req_word(g));
        if (do_chg && ci == 1) in_ratio = new_in;
      end
      if ((bus.rsp_valid & bus.rsp_ready & gmask) != 0) begin
        co++;
        chk({tag, " rsp_data"}, bus.rsp_data, bus.acc_out_data);
      end
      cb++;
      guard++;
      step();
      #1;
    end
    chk({tag, " job_timeout"}, 64'(guard < 200), 64'd1);
    chk({tag, " in_beats"}, 64'(ci), 64'(n_in));
    chk({tag, " out_beats"}, 64'(co), 64'(n_out));
    chk({tag, " busy_cycles"}, 64'(cb), 64'(n_busy));
    chk({tag, " stray"}, 64'(stray), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n_in;
    int n_out;
    in_ratio  = '0;
    out_ratio = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = req_word(i);
    bus.acc_out_data = 64'hBEEF_0000_0000_0042;

    // Job for requester 2 only, ratios 3/2, with stalls and early accelerator output
    vecs[0]  = mk(4'b0100, 1, 0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 2'd0);
    vecs[1]  = mk(4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 2'd2);
    vecs[2]  = mk(4'b0100, 0, 1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 1, 2'd2);
    vecs[3]  = mk(4'b0000, 1, 1, 4'b0100, 4'b0100, 0, 4'b0000, 0, 1, 2'd2);
    vecs[4]  = mk(4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 2'd2);
    vecs[5]  = mk(4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 2'd2);
    vecs[6]  = mk(4'b0100, 1, 1, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2'd2);
    vecs[7]  = mk(4'b0100, 1, 1, 4'b0000, 4'b0000, 0, 4'b0100, 0, 1, 2'd2);
    vecs[8]  = mk(4'b0100, 1, 0, 4'b0100, 4'b0000, 0, 4'b0000, 1, 1, 2'd2);
    vecs[9]  = mk(4'b0100, 1, 1, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2'd2);
    vecs[10] = mk(4'b0000, 1, 1, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 2'd2);

    do_reset();
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst grant", 64'(grant_id), 64'd0);
    chk("rst acc_in_valid", 64'(bus.acc_in_valid), 64'd0);
    chk("rst acc_out_ready", 64'(bus.acc_out_ready), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);

    in_ratio  = 16'd3;
    out_ratio = 16'd2;
    n_in  = 0;
    n_out = 0;
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].req_valid, vecs[k].acc_in_ready, vecs[k].acc_out_valid, vecs[k].rsp_ready);
      #1;
      chk($sformatf("v%0d req_ready", k), 64'(bus.req_ready), 64'(vecs[k].e_req_ready));
      chk($sformatf("v%0d acc_in_valid", k), 64'(bus.acc_in_valid), 64'(vecs[k].e_acc_in_valid));
      chk($sformatf("v%0d rsp_valid", k), 64'(bus.rsp_valid), 64'(vecs[k].e_rsp_valid));
      chk($sformatf("v%0d acc_out_ready", k), 64'(bus.acc_out_ready), 64'(vecs[k].e_acc_out_ready));
      chk($sformatf("v%0d busy", k), 64'(busy), 64'(vecs[k].e_busy));
      chk($sformatf("v%0d grant", k), 64'(grant_id), 64'(vecs[k].e_grant));
      if (vecs[k].e_acc_in_valid) chk($sformatf("v%0d in_data", k), bus.acc_in_data, req_word(2));
      if (bus.acc_in_valid && bus.acc_in_ready) n_in++;
      if (bus.rsp_valid[2] && bus.rsp_ready[2]) n_out++;
      step();
    end
    chk("vec in_beats", 64'(n_in), 64'd3);
    chk("vec out_beats", 64'(n_out), 64'd2);

    // Round-robin per job with all requesters valid, ratios 1/1
    do_reset();
    in_ratio  = 16'd1;
    out_ratio = 16'd1;
    drive(4'b1111, 1, 1, 4'b1111);
    run_job("rr0", 0, 1, 1, 2, 0, '0);
    run_job("rr1", 1, 1, 1, 2, 0, '0);
    run_job("rr2", 2, 1, 1, 2, 0, '0);
    run_job("rr3", 3, 1, 1, 2, 0, '0);
    run_job("rr4", 0, 1, 1, 2, 0, '0);

    // Mid-job ratio change is ignored until the next grant
    do_reset();
    in_ratio  = 16'd3;
    out_ratio = 16'd1;
    drive(4'b0001, 1, 1, 4'b1111);
    run_job("chg_a", 0, 3, 1, 4, 1, 16'd5);
    run_job("chg_b", 0, 5, 1, 6, 0, '0);

    // Zero ratios: one FEED and one DRAIN cycle, no handshakes, grant still advances
    in_ratio  = 16'd0;
    out_ratio = 16'd0;
    drive(4'b0011, 1, 1, 4'b1111);
    run_job("zero_a", 1, 0, 0, 2, 0, '0);
    run_job("zero_b", 0, 0, 0, 2, 0, '0);

    // Drain with no accelerator output (rr_ptr now 1)
    in_ratio  = 16'd1;
    out_ratio = 16'd1;
    drive(4'b0110, 1, 0, 4'b1111);
    #1;
    chk("wd idle_busy", 64'(busy), 64'd0);
    step();
    #1;
    chk("wd grant", 64'(grant_id), 64'd1);
    step();
    begin
      int bad = 0;
      for (int c = 1; c <= TMO; c++) begin
        #1;
`ifdef ACC_ARB_TIMEOUT_EN
        if (timeout_err !== (c == TMO)) bad++;
`else
        if (timeout_err !== 1'b0) bad++;
`endif
        if (busy !== 1'b1) bad++;
        step();
      end
      chk("wd drain_cycles", 64'(bad), 64'd0);
    end
    #1;
`ifdef ACC_ARB_TIMEOUT_EN
    chk("wd abort_idle", 64'(busy), 64'd0);
    chk("wd err_cleared", 64'(timeout_err), 64'd0);
    step();
    #1;
    chk("wd next_grant", 64'(grant_id), 64'd2);
    chk("wd next_busy", 64'(busy), 64'd1);
`else
    begin
      int bad = 0;
      for (int c = 0; c < 12; c++) begin
        if (busy !== 1'b1 || timeout_err !== 1'b0 || bus.acc_out_ready !== 1'b1) bad++;
        step();
        #1;
      end
      chk("wd stuck_busy", 64'(bad), 64'd0);
    end
`endif

    // Reset in the middle of a job drops it
    do_reset();
    drive(4'b0110, 1, 1, 4'b1111);
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst grant", 64'(grant_id), 64'd0);
    chk("midrst req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst acc_out_ready", 64'(bus.acc_out_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_job_arbiter.md
Name: acc_job_arbiter

Overview:
Shares one fifo-controller accelerator slot (consumer/producer valid-ready streams) between NUM_REQ requesters.
Grants the accelerator for a whole job: in_ratio input beats, then out_ratio output beats. Responses route back to the granted requester only.
Sits between the per-requester fifo_controller stream ports and a single accelerator instance. Round-robin fairness is applied per job, not per beat.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 64, stream data width (matches fifo_ctrl_pkg::data_t)
CNT_W, 16, width of job beat counters and ratio inputs
TIMEOUT_CYCLES, 1024, drain watchdog limit; used only when ACC_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_ratio  in  CNT_W  input beats per job; sampled at grant
out_ratio  in  CNT_W  output beats per job; sampled at grant
req_valid  in  NUM_REQ  per-requester input-beat valid
req_data  in  NUM_REQ*DATA_W  per-requester input data; requester i occupies [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester input-beat ready
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_data  out  DATA_W  shared response data, qualified by rsp_valid
rsp_ready  in  NUM_REQ  per-requester response ready
acc_in_valid  out  1  to accelerator consumer port
acc_in_data  out  DATA_W  to accelerator consumer port
acc_in_ready  in  1  from accelerator consumer port
acc_out_valid  in  1  from accelerator producer port
acc_out_data  in  DATA_W  from accelerator producer port
acc_out_ready  out  1  to accelerator producer port
grant_id  out  $clog2(NUM_REQ)  current or last granted requester
busy  out  1  high in S_FEED and S_DRAIN
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values (rst_n=0 at posedge):
  - state=S_IDLE, grant_id=0, rr_ptr=0 (search starts at requester 0), counters=0, latched ratios=0.
  - All ready/valid outputs and busy are 0; timeout_err is 0.
  - Data outputs are don't-care but driven from registers or muxes; no X is required.
- Reset mid-job drops the job immediately, with no further handshakes.
- States: S_IDLE, S_FEED, S_DRAIN (2-bit enum).
- S_IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap-around.
  - Latch grant_id, in_ratio and out_ratio; clear in_cnt and out_cnt; go to S_FEED next cycle.
  - No handshake occurs in S_IDLE. Arbitration latency is 1 cycle.
- S_FEED (combinational pass-through for granted g):
  - acc_in_valid = req_valid[g]; acc_in_data = req_data[g]; req_ready[g] = acc_in_ready.
  - All other req_ready bits are 0.
  - in_cnt increments on each acc_in handshake.
  - Go to S_DRAIN when in_cnt_next == latched in_ratio.
  - Latched in_ratio == 0 goes to S_DRAIN after one cycle with acc_in_valid forced 0.
- S_DRAIN:
  - rsp_valid[g] = acc_out_valid; rsp_data = acc_out_data; acc_out_ready = rsp_ready[g].
  - Other rsp_valid bits are 0.
  - out_cnt increments per handshake.
  - When out_cnt_next == latched out_ratio, go to S_IDLE and set rr_ptr = (g+1) mod NUM_REQ.
  - out_ratio == 0 returns to S_IDLE after one cycle.
- acc_out_ready=0 outside S_DRAIN. Early accelerator output is stalled, not dropped.
- acc_in_valid=0 and all req_ready=0 outside S_FEED.
- Changes to in_ratio/out_ratio mid-job have no effect until the next grant.
- Counters are CNT_W bits and compared for equality only. A ratio of 2^CNT_W-1 is legal; counters never wrap within a job.
- Back-to-back jobs: minimum 1 idle cycle between jobs (the S_IDLE arbitration cycle).
- A requester dropping req_valid mid-feed keeps the grant; the arbiter simply waits.

Optional Feature:
ACC_ARB_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to S_DRAIN and on every acc_out handshake.
  - It increments on other S_DRAIN cycles.
  - On reaching TIMEOUT_CYCLES: go to S_IDLE, advance rr_ptr past g, and pulse timeout_err for 1 cycle.
  - Remaining accelerator output is stalled by acc_out_ready=0 until the next job's drain.
- Not defined: no watchdog logic; timeout_err is tied 0; S_DRAIN waits indefinitely.

Test Plan:
- Reset, then NUM_REQ=4, in_ratio=3, out_ratio=2, only req 2 valid -> grant_id=2 one cycle later; exactly 3 acc_in beats, then 2 rsp beats on rsp_valid[2] only; busy falls after the 2nd response handshake.
- All 4 requesters hold valid, ratios 1/1 -> grants in order 0,1,2,3,0; one idle cycle between jobs.
- acc_out_valid=1 during S_FEED -> acc_out_ready stays 0 until S_DRAIN; no response beat is lost or duplicated.
- in_ratio changes 3->5 after the first input beat -> the job still completes after 3 beats; the next grant uses 5.
- in_ratio=0, out_ratio=0 -> FEED and DRAIN each last 1 cycle with no handshakes; the grant advances.
- With ACC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, acc_out_valid held 0 in S_DRAIN -> timeout_err pulses on the 8th drain cycle, state returns to S_IDLE, and the next requester is granted. Without the macro -> timeout_err stays 0 and busy stays 1.
